// File: rtl/plab5_mcore_net_req_inject_queue_pkg.sv
// Shared definitions for the domain-aware request injection queue:
// FSM state encodings and the location of the domain bit in the control field.
package plab5_mcore_net_req_inject_queue_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SCRUB = 2'd2
    } inject_state_e;

    // The request domain bit is carried in the MSB of the control message.
    function automatic int unsigned ctrl_domain_pos(input int unsigned ctrl_nbits);
        return ctrl_nbits - 1;
    endfunction

endpackage

// File: rtl/plab5_mcore_net_req_inject_queue_ctrl.sv
// Control half of the injection queue: pointers, occupancy, the
// RUN/DRAIN/SCRUB domain-change sequencer and the handshake decode.
module plab5_mcore_net_req_inject_queue_ctrl
    import plab5_mcore_net_req_inject_queue_pkg::*;
#(
    parameter  int p_num_entries = 2,
    localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    domain,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic                    wr_en,
    output logic [c_addr_nbits-1:0] wr_addr,
    output logic [c_addr_nbits-1:0] rd_addr,
    output logic                    scrub,
    output logic                    q_domain,
    output logic                    drain_busy
);

    localparam logic [c_addr_nbits:0]   c_depth   = (c_addr_nbits+1)'(p_num_entries);
    localparam logic [c_addr_nbits:0]   c_cnt_one = (c_addr_nbits+1)'(1);
    localparam logic [c_addr_nbits-1:0] c_ptr_one = c_addr_nbits'(1);

    inject_state_e             state_q, state_d;
    logic [c_addr_nbits-1:0]   head_q, head_d;
    logic [c_addr_nbits-1:0]   tail_q, tail_d;
    logic [c_addr_nbits:0]     count_q, count_d;
    logic                      q_domain_q, q_domain_d;
    logic                      enq;
    logic                      deq;
    logic                      empty;

    assign empty   = (count_q == '0);
    // in_rdy is gated by reset so nothing is accepted while it is held low.
    assign in_rdy  = reset && (state_q == ST_RUN) && (count_q < c_depth)
                     && (empty || (domain == q_domain_q));
    assign out_val = !empty && (state_q != ST_SCRUB);
    assign enq     = in_val && in_rdy;
    assign deq     = out_val && out_rdy;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        q_domain_d = q_domain_q;

        if (enq) tail_d = tail_q + c_ptr_one;
        if (deq) head_d = head_q + c_ptr_one;

        case ({enq, deq})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (enq && empty) q_domain_d = domain;
                if (!empty && (domain != q_domain_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Drain always runs to completion, even if the domain flips back.
                if (count_d == '0) state_d = ST_SCRUB;
            end
            ST_SCRUB: begin
                q_domain_d = domain;
                head_d     = '0;
                tail_d     = '0;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            q_domain_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            q_domain_q <= q_domain_d;
        end
    end

    assign wr_en      = enq;
    assign wr_addr    = tail_q;
    assign rd_addr    = head_q;
    assign scrub      = (state_q == ST_SCRUB);
    assign q_domain   = q_domain_q;
    assign drain_busy = (state_q != ST_RUN);

endmodule

// File: rtl/plab5_mcore_net_req_inject_queue.sv
// Domain-aware injection queue feeding the request-network router; owns the
// entry storage and head-of-queue output muxing.
module plab5_mcore_net_req_inject_queue
    import plab5_mcore_net_req_inject_queue_pkg::*;
#(
    parameter  int p_num_entries = 2,
    parameter  int p_ctrl_nbits  = 44,
    parameter  int p_data_nbits  = 32,
    localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    domain,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [p_ctrl_nbits-1:0] in_msg_control,
    input  logic [p_data_nbits-1:0] in_msg_data,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_ctrl_nbits-1:0] out_msg_control,
    output logic [p_data_nbits-1:0] out_msg_data,
    output logic                    out_domain,
    output logic                    drain_busy
);

    logic [p_ctrl_nbits-1:0] ctrl_mem_q [p_num_entries];
    logic [p_data_nbits-1:0] data_mem_q [p_num_entries];

    logic                    wr_en;
    logic [c_addr_nbits-1:0] wr_addr;
    logic [c_addr_nbits-1:0] rd_addr;
    logic                    scrub;

    plab5_mcore_net_req_inject_queue_ctrl #(
        .p_num_entries (p_num_entries)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .domain     (domain),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .scrub      (scrub),
        .q_domain   (out_domain),
        .drain_busy (drain_busy)
    );

    // Scrub and write never coincide: in_rdy is low outside RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                ctrl_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (scrub) begin
            for (int i = 0; i < p_num_entries; i++) begin
                data_mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            ctrl_mem_q[wr_addr] <= in_msg_control;
            data_mem_q[wr_addr] <= in_msg_data;
        end
    end

    // Head entry is only exposed while valid so no stale payload leaks out.
    assign out_msg_control = out_val ? ctrl_mem_q[rd_addr] : '0;
    assign out_msg_data    = out_val ? data_mem_q[rd_addr] : '0;

endmodule
